// File: rtl/muldiv_unit.sv
// Iterative MULTU/MULT/DIVU/DIV unit producing a MIPS-style HI/LO pair.
// The unit uses a start/done handshake, runs WIDTH iterations and then one fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [1:0]         op_r;       // op_r[1]: divide, op_r[0]: signed
    logic [WIDTH-1:0]   ma;         // multiplicand magnitude
    logic [WIDTH-1:0]   mb;         // multiplier / divisor magnitude
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc;        // product, or dividend/quotient in the low half
    logic [WIDTH-1:0]   rem_r;
    logic               neg_q;
    logic               neg_r;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;

    assign abs_a      = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b      = (op[0] && b[WIDTH-1]) ? -b : b;
    assign mul_addend = acc[0] ? ma : '0;
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    // Partial remainder stays below the divisor, so WIDTH stored bits suffice.
    assign div_shift  = {rem_r, acc[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, mb};

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            op_r   <= '0;
            ma     <= '0;
            mb     <= '0;
            a_orig <= '0;
            acc    <= '0;
            rem_r  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        count  <= '0;
                        op_r   <= op;
                        ma     <= abs_a;
                        mb     <= abs_b;
                        a_orig <= a;
                        acc    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        rem_r  <= '0;
                        neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r  <= a[WIDTH-1];
                    end
                end
                RUN: begin
                    if (!op_r[1]) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else if (!div_trial[WIDTH]) begin
                        rem_r            <= div_trial[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r            <= div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                    end
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (!op_r[1]) begin
                        {hi, lo} <= (op_r[0] && neg_q) ? -acc : acc;
                        dz       <= 1'b0;
                    end else if (mb == '0) begin
                        lo <= '1;
                        hi <= a_orig;
                        dz <= 1'b1;
                    end else begin
                        lo <= (op_r[0] && neg_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        hi <= (op_r[0] && neg_r) ? -rem_r : rem_r;
                        dz <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
